// File: rtl/fuzz_resp_capture.sv
// fuzz_resp_capture
// Captures stimulus/response pairs from a fuzzing harness into a small
// show-ahead record FIFO and folds every accepted pair into a MISR
// signature. A run is started with a single-cycle start pulse and accepts
// exactly num_iters pairs. It then drains the FIFO and parks in DONE.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, num_iters  begin a run (honoured only in IDLE/DONE) and set its length
//   s_valid/s_ready   upstream pair handshake, carrying dut_in / dut_out
//   m_valid/m_ready   record readout handshake, carrying m_iter / m_in / m_out
//   signature         running MISR over {dut_in, dut_out} of accepted pairs
//   busy, done        busy is high in RUN or DRAIN; done is high in DONE
module fuzz_resp_capture #(
  parameter int                IN_W   = 7,
  parameter int                OUT_W  = 8,
  parameter int                DEPTH  = 8,
  parameter int                ITER_W = 5,
  parameter int                SIG_W  = 16,
  parameter logic [SIG_W-1:0]  POLY   = 16'h1021
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ITER_W-1:0] num_iters,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ITER_W-1:0] m_iter,
  output logic [IN_W-1:0]   m_in,
  output logic [OUT_W-1:0]  m_out,
  output logic [SIG_W-1:0]  signature,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One MISR step: shift with polynomial feedback, then fold in the pair.
  // dut_in occupies the bits above dut_out.
  function automatic logic [SIG_W-1:0] misr_next(
    input logic [SIG_W-1:0] sig,
    input logic [IN_W-1:0]  din,
    input logic [OUT_W-1:0] dout
  );
    logic [SIG_W-1:0] sh;
    sh = {sig[SIG_W-2:0], 1'b0};
    if (sig[SIG_W-1]) begin
      sh = sh ^ POLY;
    end else begin
      sh = sh;
    end
    return sh ^ SIG_W'({din, dout});
  endfunction

  state_t              state_q, state_d;
  logic [ITER_W-1:0]   count_q, count_d;
  logic [ITER_W-1:0]   iters_q, iters_d;
  logic [SIG_W-1:0]    sig_q, sig_d;
  // Pointers carry one extra bit so that full and empty are distinguishable.
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;

  logic [ITER_W-1:0]   iter_mem [DEPTH];
  logic [IN_W-1:0]     in_mem   [DEPTH];
  logic [OUT_W-1:0]    out_mem  [DEPTH];

  logic                empty_s, full_s, push_s, pop_s;
  logic [ITER_W-1:0]   count_inc_s;
  logic [AW-1:0]       rd_idx_s;

  assign empty_s     = (wr_ptr_q == rd_ptr_q);
  assign full_s      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign s_ready     = (state_q == RUN) && !full_s;
  assign m_valid     = !empty_s;
  assign push_s      = s_valid && s_ready;
  assign pop_s       = m_valid && m_ready;
  assign count_inc_s = count_q + {{(ITER_W-1){1'b0}}, 1'b1};
  assign rd_idx_s    = rd_ptr_q[AW-1:0];

  // Record fields read as zero whenever no record is presented, which also
  // covers the reset state without needing to reset the storage array.
  assign m_iter    = m_valid ? iter_mem[rd_idx_s] : {ITER_W{1'b0}};
  assign m_in      = m_valid ? in_mem[rd_idx_s]   : {IN_W{1'b0}};
  assign m_out     = m_valid ? out_mem[rd_idx_s]  : {OUT_W{1'b0}};
  assign signature = sig_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

  // Next-state logic for the FSM, run counters, signature and FIFO pointers.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    iters_d  = iters_q;
    sig_d    = sig_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      count_d  = count_inc_s;
      sig_d    = misr_next(sig_q, dut_in, dut_out);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case (state_q)
      IDLE, DONE: begin
        // start clears everything, including any pop seen this cycle.
        if (start) begin
          iters_d  = num_iters;
          count_d  = {ITER_W{1'b0}};
          sig_d    = {SIG_W{1'b0}};
          wr_ptr_d = {(AW+1){1'b0}};
          rd_ptr_d = {(AW+1){1'b0}};
          if (num_iters == {ITER_W{1'b0}}) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (push_s && (count_inc_s == iters_q)) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        // No push can be pending here because s_ready is low outside RUN.
        if (empty_s) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, signature and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= {ITER_W{1'b0}};
      iters_q  <= {ITER_W{1'b0}};
      sig_q    <= {SIG_W{1'b0}};
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      iters_q  <= iters_d;
      sig_q    <= sig_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Record storage. The write lands at the push edge, and the record becomes
  // visible one cycle later.
  always_ff @(posedge clk) begin
    if (push_s) begin
      iter_mem[wr_ptr_q[AW-1:0]] <= count_q;
      in_mem[wr_ptr_q[AW-1:0]]   <= dut_in;
      out_mem[wr_ptr_q[AW-1:0]]  <= dut_out;
    end
  end

endmodule
